edge_detect_stream: RTL

- Parametrised, handshaked successor to the fixed 8-bit edge-detection top.
- Streams one line of LINE_LEN samples through four stages: 3-tap smoothing, signed first difference, a runtime-programmable threshold with polarity selection, and a persistence filter that needs PERSIST consecutive hits.
- Emits one edge flag per accepted sample and marks the last sample of each line.
- Sits between the sample source (file/frame reader) and the edge buffer.

---
 rtl/edge_pkg.sv | 19 +
 rtl/edge_persist.sv | 63 ++++++
 rtl/edge_detect_stream.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared encodings for the edge-detection stream block and its reusable helpers.
package edge_pkg;

    localparam int unsigned LAT = 3;

    typedef enum logic [1:0] {
        MODE_BOTH = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        LINE_END = 2'b10
    } state_e;

endpackage

// File: rtl/edge_persist.sv
// Saturating run-length filter on per-sample hits plus the last-flag delay stage.
// Forms the final pipeline stage; the run is dropped after a line's last sample.
module edge_persist
    import edge_pkg::*;
#(
    parameter int unsigned PERSIST = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enb,
    input  logic clear,
    input  logic in_valid,
    input  logic in_hit,
    input  logic in_last,
    output logic out_valid,
    output logic out_edge,
    output logic out_last
);

    localparam logic [3:0] PersistCnt = 4'(PERSIST);

    logic [3:0] run_q;
    logic [3:0] run_d;
    logic [3:0] run_next;
    logic       valid_q;
    logic       edge_q;
    logic       last_q;

    always_comb begin
        run_next = '0;
        if (in_hit) begin
            run_next = (run_q >= PersistCnt) ? PersistCnt : run_q + 4'd1;
        end
        run_d = run_q;
        if (in_valid) begin
            run_d = in_last ? '0 : run_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q   <= '0;
            valid_q <= 1'b0;
            edge_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (clear) begin
            run_q   <= '0;
            valid_q <= 1'b0;
            edge_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (enb) begin
            run_q   <= run_d;
            valid_q <= in_valid;
            edge_q  <= in_valid && (run_next >= PersistCnt);
            last_q  <= in_valid && in_last;
        end
    end

    assign out_valid = valid_q;
    assign out_edge  = edge_q;
    assign out_last  = last_q;

endmodule

// File: rtl/edge_detect_stream.sv
// Handshaked line edge detector: 3-tap smooth, first difference, threshold, persistence.
// Optional per-line edge counter enabled by macro EDGE_DETECT_STREAM_COUNT_EN.
module edge_detect_stream
    import edge_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned LINE_LEN = 640,
    parameter int unsigned PERSIST  = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enb,
    input  logic          flush,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] threshold,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic          out_edge,
    output logic          out_last,
    output logic          busy
`ifdef EDGE_DETECT_STREAM_COUNT_EN
    ,
    output logic [$clog2(LINE_LEN+1)-1:0] edge_count
`endif
);

    localparam int unsigned IW = $clog2(LINE_LEN);
    localparam logic [IW-1:0] LastIdx = IW'(LINE_LEN - 1);

    if (DW < 4) begin : g_bad_dw
        $error("DW must be at least 4");
    end
    if (LINE_LEN < 4) begin : g_bad_len
        $error("LINE_LEN must be at least 4");
    end
    if (PERSIST < 1 || PERSIST > 15) begin : g_bad_persist
        $error("PERSIST must be in 1..15");
    end

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] thr_q;
    mode_e         mode_q;
    logic [DW-1:0] x1_q, x2_q, sp_q;

    logic              accept;
    logic              hist_clear;
    logic [DW+1:0]     sum;
    logic [DW-1:0]     s_cur;
    logic signed [DW:0] d_cur;
    logic              prime_cur;
    logic              last_cur;

    logic              v1_q, p1_q, l1_q;
    logic signed [DW:0] d1_q;
    logic              v2_q, h2_q, l2_q;

    logic signed [DW+1:0] dx, nd, tx;
    logic              hit_raw;
    logic              p_valid, p_edge, p_last;

    assign in_ready   = enb && reset && (state_q != LINE_END);
    // Flush wins over a simultaneous accept.
    assign accept     = in_valid && in_ready && !flush;
    assign hist_clear = flush || (enb && state_q == LINE_END);

    assign sum       = {2'b00, x2_q} + {1'b0, x1_q, 1'b0} + {2'b00, in_data};
    assign s_cur     = sum[DW+1:2];
    assign d_cur     = $signed({1'b0, s_cur}) - $signed({1'b0, sp_q});
    assign prime_cur = (idx_q < IW'(3));
    assign last_cur  = (state_q == RUN) && (idx_q == LastIdx);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    idx_d   = IW'(1);
                end
            end
            RUN: begin
                if (accept) begin
                    if (idx_q == LastIdx) begin
                        state_d = LINE_END;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            LINE_END: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else if (flush || enb) begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Line-local tap history plus the line-start shadow of threshold and mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x1_q   <= '0;
            x2_q   <= '0;
            sp_q   <= '0;
            thr_q  <= '0;
            mode_q <= MODE_BOTH;
        end else if (hist_clear) begin
            x1_q <= '0;
            x2_q <= '0;
            sp_q <= '0;
        end else if (accept) begin
            x2_q <= x1_q;
            x1_q <= in_data;
            sp_q <= s_cur;
            if (state_q == IDLE) begin
                thr_q  <= threshold;
                mode_q <= mode_e'(mode);
            end
        end
    end

    assign dx = {d1_q[DW], d1_q};
    assign nd = -dx;
    assign tx = {2'b00, thr_q};

    always_comb begin
        hit_raw = 1'b0;
        unique case (mode_q)
            MODE_BOTH: hit_raw = (dx > tx) || (nd > tx);
            MODE_RISE: hit_raw = (dx > tx);
            MODE_FALL: hit_raw = (nd > tx);
            MODE_OFF:  hit_raw = 1'b0;
            default:   hit_raw = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q <= 1'b0;
            d1_q <= '0;
            p1_q <= 1'b0;
            l1_q <= 1'b0;
            v2_q <= 1'b0;
            h2_q <= 1'b0;
            l2_q <= 1'b0;
        end else if (flush) begin
            v1_q <= 1'b0;
            p1_q <= 1'b0;
            l1_q <= 1'b0;
            v2_q <= 1'b0;
            h2_q <= 1'b0;
            l2_q <= 1'b0;
        end else if (enb) begin
            v1_q <= accept;
            d1_q <= d_cur;
            p1_q <= prime_cur;
            l1_q <= accept && last_cur;
            v2_q <= v1_q;
            h2_q <= v1_q && hit_raw && !p1_q;
            l2_q <= v1_q && l1_q;
        end
    end

    edge_persist #(
        .PERSIST(PERSIST)
    ) u_persist (
        .clk      (clk),
        .reset    (reset),
        .enb      (enb),
        .clear    (flush),
        .in_valid (v2_q),
        .in_hit   (h2_q),
        .in_last  (l2_q),
        .out_valid(p_valid),
        .out_edge (p_edge),
        .out_last (p_last)
    );

    // The final stage only advances while enabled, so each result shows exactly once.
    assign out_valid = p_valid && enb;
    assign out_edge  = p_edge && out_valid;
    assign out_last  = p_last && out_valid;
    assign busy      = v1_q || v2_q || p_valid || (state_q != IDLE);

`ifdef EDGE_DETECT_STREAM_COUNT_EN
    localparam int unsigned CW = $clog2(LINE_LEN + 1);

    logic [CW-1:0] acc_q, held_q, acc_inc;

    assign acc_inc = acc_q + CW'(out_edge);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            held_q <= '0;
        end else if (flush) begin
            acc_q  <= '0;
            held_q <= '0;
        end else if (out_valid) begin
            if (out_last) begin
                held_q <= acc_inc;
                acc_q  <= '0;
            end else begin
                acc_q <= acc_inc;
            end
        end
    end

    assign edge_count = (out_valid && out_last) ? acc_inc : held_q;
`endif

endmodule
